axi_stream_master_fifo: RTL and testbench

Parametrised AXI-Stream master output stage with a DEPTH-entry elastic buffer between the authentication/encryption core and the system sink. Absorbs sink backpressure (`ready_sys` low) without losing words by pushing backpressure upstream via `ready_out`. Next generation of the single-register stream master: adds configurable depth, upstream handshake, fill-level reporting, flush, and optional packet framing.

---
 rtl/axi_stream_master_fifo.sv | 118 +++++++++++
 tb/tb_axi_stream_master_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_master_fifo.sv
// axi_stream_master_fifo
// DEPTH-entry circular elastic buffer between an upstream producer and an
// AXI-Stream sink. Sink backpressure fills the buffer, and a full buffer
// pushes back upstream through ready_out.
// Optional packet framing (last_in / last_out) is built when the macro
// AXIS_MASTER_LAST_EN is defined. Without it, those ports are absent.
//
// Handshake: a word moves on a rising edge where both its valid and its
// ready are high (valid_input/ready_out upstream, valid/ready_sys
// downstream). valid never waits for ready. Once valid is high, data_out
// and last_out stay stable until the sink accepts the word. ready_out comes
// only from the registered level and never from ready_sys.
module axi_stream_master_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid_input,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    input  logic                  ready_sys,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      level
`ifdef AXIS_MASTER_LAST_EN
    ,
    input  logic                  last_in,
    output logic                  last_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
`ifdef AXIS_MASTER_LAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   level_q, level_d;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake qualifiers are derived from registered level only.
    assign ready_out = (level_q != FULL_LEVEL);
    assign valid     = (level_q != '0);
    assign push      = valid_input && ready_out;
    assign pop       = valid && ready_sys;
    assign level     = level_q;

`ifdef AXIS_MASTER_LAST_EN
    assign wr_entry = {last_in, data_in};
`else
    assign wr_entry = data_in;
`endif

    // The head entry is shown directly. An empty buffer is masked to zero
    // because the storage itself is never cleared.
    assign rd_entry = mem_q[rd_ptr_q];
    assign data_out = valid ? rd_entry[DATA_WIDTH-1:0] : '0;
`ifdef AXIS_MASTER_LAST_EN
    assign last_out = valid & rd_entry[DATA_WIDTH];
`endif

    // Next pointers and fill count. Flush wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers. Reset performs the same clear as flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write. Contents are never reset. Words offered during a clear are dropped.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_axi_stream_master_fifo.sv
// tb_axi_stream_master_fifo
// Directed vector table, hand-written corner sequences, and randomized traffic.
// The traffic is checked against a queue-based reference model.
// Framing checks are built only when AXIS_MASTER_LAST_EN is defined.
module tb_axi_stream_master_fifo;
  localparam int W  = 512;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          valid_input;
  logic [W-1:0]  data_in;
  logic          ready_out;
  logic          ready_sys;
  logic          valid;
  logic [W-1:0]  data_out;
  logic [CW-1:0] level;
`ifdef AXIS_MASTER_LAST_EN
  logic          last_in;
  logic          last_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is an in-order queue of words, plus a parallel queue of last flags.
  logic [W-1:0] exp_q[$];
  logic         lst_q[$];

  typedef struct {
    logic         vin;
    logic [W-1:0] din;
    logic         rs;
    logic         fl;
    logic         e_valid;
    logic         e_ready;
    int           e_level;
    logic [W-1:0] e_data;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  axi_stream_master_fifo #(.DATA_WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .valid_input(valid_input),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .ready_sys  (ready_sys),
    .valid      (valid),
    .data_out   (data_out),
    .level      (level)
`ifdef AXIS_MASTER_LAST_EN
    ,
    .last_in    (last_in),
    .last_out   (last_out)
`endif
  );

  // clock
  always #5 clk = ~clk;

  function automatic vec_t mk(logic vin, logic [W-1:0] din, logic rs, logic fl,
                              logic ev, logic er, int el, logic [W-1:0] ed);
    vec_t v;
    v.vin = vin; v.din = din; v.rs = rs; v.fl = fl;
    v.e_valid = ev; v.e_ready = er; v.e_level = el; v.e_data = ed;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply the spec rules to the model for one edge, using pre-edge occupancy.
  task automatic model_edge(input logic vin, input logic [W-1:0] din, input logic rs,
                            input logic fl, input logic lst);
    bit do_push;
    bit do_pop;
    do_push = vin && (exp_q.size() < D);
    do_pop  = rs && (exp_q.size() > 0);
    if (reset || fl) begin
      exp_q.delete();
      lst_q.delete();
    end else begin
      if (do_pop) begin
        exp_q.delete(0);
        lst_q.delete(0);
      end
      if (do_push) begin
        exp_q.push_back(din);
        lst_q.push_back(lst);
      end
    end
  endtask

  // driver: set inputs, update the model, advance past the edge
  task automatic drive_edge(input logic vin, input logic [W-1:0] din, input logic rs,
                            input logic fl, input logic lst);
    valid_input = vin;
    data_in     = din;
    ready_sys   = rs;
    flush       = fl;
`ifdef AXIS_MASTER_LAST_EN
    last_in     = lst;
`endif
    model_edge(vin, din, rs, fl, lst);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) drive_edge(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_model(input string name);
    logic [W-1:0] e_d;
    e_d = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({name, ".valid"}, W'(valid), W'(exp_q.size() != 0));
    chk({name, ".ready_out"}, W'(ready_out), W'(exp_q.size() < D));
    chk({name, ".level"}, W'(level), W'(exp_q.size()));
    chk({name, ".data_out"}, data_out, e_d);
`ifdef AXIS_MASTER_LAST_EN
    chk({name, ".last_out"}, W'(last_out), W'((exp_q.size() != 0) ? lst_q[0] : 1'b0));
`endif
  endtask

  task automatic chk_const(input string name, input logic ev, input logic er,
                           input int el, input logic [W-1:0] ed);
    chk({name, ".valid"}, W'(valid), W'(ev));
    chk({name, ".ready_out"}, W'(ready_out), W'(er));
    chk({name, ".level"}, W'(level), W'(el));
    chk({name, ".data_out"}, data_out, ed);
  endtask

  initial begin
    logic [W-1:0] w_a5;
    logic [W-1:0] w_big;
    logic         r_vin;
    logic         r_rs;
    logic         r_fl;
    w_a5  = 'hA5A5A5A5A5A5A5A5;
    w_big = 'h1234567890ABCDEF;

    // directed vector table: inputs for one edge, then outputs expected after it
    vecs[0]  = mk(1, 'h1,  1, 0,  1, 1, 1, 'h1);
    vecs[1]  = mk(1, 'h2,  1, 0,  1, 1, 1, 'h2);
    vecs[2]  = mk(1, 'h3,  1, 0,  1, 1, 1, 'h3);
    vecs[3]  = mk(0, '0,   1, 0,  0, 1, 0, '0);
    vecs[4]  = mk(1, w_a5, 0, 0,  1, 1, 1, w_a5);
    vecs[5]  = mk(1, 'hB,  0, 0,  1, 1, 2, w_a5);
    vecs[6]  = mk(1, 'hC,  0, 0,  1, 1, 3, w_a5);
    vecs[7]  = mk(1, 'hD,  0, 0,  1, 0, 4, w_a5);
    vecs[8]  = mk(1, 'hE,  0, 0,  1, 0, 4, w_a5);
    vecs[9]  = mk(0, '0,   1, 0,  1, 1, 3, 'hB);
    vecs[10] = mk(0, '0,   1, 0,  1, 1, 2, 'hC);
    vecs[11] = mk(0, '0,   1, 0,  1, 1, 1, 'hD);
    vecs[12] = mk(0, '0,   1, 0,  0, 1, 0, '0);
    vecs[13] = mk(1, 'h11, 0, 0,  1, 1, 1, 'h11);
    vecs[14] = mk(1, 'h12, 0, 0,  1, 1, 2, 'h11);
    vecs[15] = mk(1, 'h13, 0, 0,  1, 1, 3, 'h11);
    vecs[16] = mk(1, 'h14, 0, 0,  1, 0, 4, 'h11);
    vecs[17] = mk(1, w_big, 1, 0, 1, 1, 3, 'h12);
    vecs[18] = mk(1, w_big, 1, 0, 1, 1, 3, 'h13);
    vecs[19] = mk(1, 'h55, 0, 1,  0, 1, 0, '0);
    vecs[20] = mk(0, '0,   1, 0,  0, 1, 0, '0);

    reset = 1'b1; flush = 1'b0; valid_input = 1'b0; ready_sys = 1'b0; data_in = '0;
`ifdef AXIS_MASTER_LAST_EN
    last_in = 1'b0;
`endif

    // reset state
    do_reset(3);
    chk_const("reset", 1'b0, 1'b1, 0, '0);
`ifdef AXIS_MASTER_LAST_EN
    chk("reset.last_out", W'(last_out), '0);
`endif

    // table-driven directed vectors
    for (int i = 0; i < NV; i++) begin
      drive_edge(vecs[i].vin, vecs[i].din, vecs[i].rs, vecs[i].fl, 1'b0);
      chk_const($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_level, vecs[i].e_data);
    end

    // reset mid-transfer, together with flush and a push: everything is cleared
    drive_edge(1'b1, 'h71, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 'h72, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 'h73, 1'b0, 1'b0, 1'b0);
    chk_const("midfill", 1'b1, 1'b1, 3, 'h71);
    reset = 1'b1;
    drive_edge(1'b1, 'h99, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk_const("mid_reset", 1'b0, 1'b1, 0, '0);
    drive_edge(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_const("post_reset", 1'b0, 1'b1, 0, '0);

    // flush concurrent with both pop and push
    drive_edge(1'b1, 'h81, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 'h82, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 'h77, 1'b1, 1'b1, 1'b0);
    chk_const("flush_pop", 1'b0, 1'b1, 0, '0);
    drive_edge(1'b1, 'h83, 1'b1, 1'b0, 1'b0);
    chk_const("refill", 1'b1, 1'b1, 1, 'h83);
    drive_edge(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_const("redrain", 1'b0, 1'b1, 0, '0);

`ifdef AXIS_MASTER_LAST_EN
    // framing: last travels with its word and holds through a stall
    drive_edge(1'b1, 'h1, 1'b0, 1'b0, 1'b0);
    chk("frm0.last_out", W'(last_out), '0);
    drive_edge(1'b1, 'h2, 1'b0, 1'b0, 1'b1);
    chk_const("frm1", 1'b1, 1'b1, 2, 'h1);
    chk("frm1.last_out", W'(last_out), '0);
    for (int s = 0; s < 2; s++) begin
      drive_edge(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk_const($sformatf("frm_stall%0d", s), 1'b1, 1'b1, 2, 'h1);
      chk($sformatf("frm_stall%0d.last_out", s), W'(last_out), '0);
    end
    drive_edge(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_const("frm2", 1'b1, 1'b1, 1, 'h2);
    chk("frm2.last_out", W'(last_out), W'(1'b1));
    drive_edge(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("frm2_stall.last_out", W'(last_out), W'(1'b1));
    drive_edge(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_const("frm3", 1'b0, 1'b1, 0, '0);
    chk("frm3.last_out", W'(last_out), '0);
`endif

    // randomized traffic against the queue model, with varying sink pressure
    for (int c = 0; c < 900; c++) begin
      r_vin = ($urandom_range(0, 3) != 0);
      if (c < 300)      r_rs = ($urandom_range(0, 3) == 0);
      else if (c < 600) r_rs = ($urandom_range(0, 1) == 0);
      else              r_rs = ($urandom_range(0, 7) != 0);
      r_fl = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 127) == 0) reset = 1'b1;
      drive_edge(r_vin, rand_word(), r_rs, r_fl, 1'($urandom_range(0, 1)));
      reset = 1'b0;
      chk_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
